// File: rtl/feed_msg_decoder_if.sv
// Handshake and command bundle between the feed byte source, the message decoder and the
// book builder.
//   in_data/in_valid/in_ready : feed byte stream (transfer = in_valid & in_ready)
//   book_ready                : book builder can take a command
//   start + operands          : one command per decoded message
//   msg_count/err_count       : saturating good/bad message counters
//   msg_error                 : one-cycle pulse per error event
// slave is the decoder side; master is the feed/book side, which the bench also uses.
interface feed_msg_decoder_if #(
  parameter int unsigned STOCK_W = 2,
  parameter int unsigned ORDER_W = 16,
  parameter int unsigned PRICE_W = 16,
  parameter int unsigned QTY_W   = 16
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               book_ready;
  logic               start;
  logic [2:0]         request;
  logic [STOCK_W-1:0] stock_to_add;
  logic [ORDER_W-1:0] order_id;
  logic               side;
  logic [PRICE_W-1:0] price;
  logic [QTY_W-1:0]   quantity;
  logic               delete;
  logic [15:0]        msg_count;
  logic [15:0]        err_count;
  logic               msg_error;

  modport slave (
    input  in_data, in_valid, book_ready,
    output in_ready, start, request, stock_to_add, order_id, side, price, quantity, delete,
           msg_count, err_count, msg_error
  );

  modport master (
    output in_data, in_valid, book_ready,
    input  in_ready, start, request, stock_to_add, order_id, side, price, quantity, delete,
           msg_count, err_count, msg_error
  );
endinterface

// File: rtl/feed_msg_decoder.sv
// Market-data feed decoder. Parses big-endian Add ('A', 9 bytes), Cancel ('X', 4 bytes) and
// Execute ('E', 6 bytes) messages from a byte stream and issues one command per valid message
// to the book builder.
// Ports:
//   clk_100mhz : system clock
//   reset      : asynchronous active-high reset
//   bus        : feed_msg_decoder_if.slave (byte stream in, command/counters out)
module feed_msg_decoder #(
  parameter int unsigned STOCK_W = 2,
  parameter int unsigned ORDER_W = 16,
  parameter int unsigned PRICE_W = 16,
  parameter int unsigned QTY_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic                clk_100mhz,
  input logic                reset,
  feed_msg_decoder_if.slave  bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFields = 2'd1;
  localparam logic [1:0] StIssue  = 2'd2;

  localparam logic [7:0] TypeAdd = 8'h41;
  localparam logic [7:0] TypeCxl = 8'h58;
  localparam logic [7:0] TypeExe = 8'h45;

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IdleLast = TW'(TIMEOUT - 1);
  localparam logic [8:0]    StockLim = 9'(1 << STOCK_W);

  logic [1:0]  state_q, state_d;
  logic [7:0]  type_q, type_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ok_q, ok_d;
  logic [TW-1:0] idle_q, idle_d;
  // Raw wire-width field accumulators; cleared at each message start so unused fields read 0.
  logic [7:0]  acc_stk_q, acc_stk_d;
  logic [15:0] acc_oid_q, acc_oid_d;
  logic        acc_sid_q, acc_sid_d;
  logic [15:0] acc_prc_q, acc_prc_d;
  logic [15:0] acc_qty_q, acc_qty_d;
  // Command outputs, loaded only on entry to StIssue.
  logic [2:0]         req_q, req_d;
  logic [STOCK_W-1:0] stk_q, stk_d;
  logic [ORDER_W-1:0] oid_q, oid_d;
  logic               sid_q, sid_d;
  logic [PRICE_W-1:0] prc_q, prc_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic               del_q, del_d;
  logic        start_q, start_d;
  logic        err_q, err_d;
  logic [15:0] msg_cnt_q, msg_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic       in_ready;
  logic       accept;
  logic [3:0] last_idx;

  assign in_ready = ~reset & (state_q != StIssue);
  assign accept   = bus.in_valid & in_ready;
  assign last_idx = (type_q == TypeAdd) ? 4'd8 : (type_q == TypeCxl) ? 4'd3 : 4'd5;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    ok_d      = ok_q;
    idle_d    = idle_q;
    acc_stk_d = acc_stk_q;
    acc_oid_d = acc_oid_q;
    acc_sid_d = acc_sid_q;
    acc_prc_d = acc_prc_q;
    acc_qty_d = acc_qty_q;
    req_d     = req_q;
    stk_d     = stk_q;
    oid_d     = oid_q;
    sid_d     = sid_q;
    prc_d     = prc_q;
    qty_d     = qty_q;
    del_d     = del_q;
    start_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.in_data == TypeAdd || bus.in_data == TypeCxl || bus.in_data == TypeExe) begin
            type_d    = bus.in_data;
            cnt_d     = 4'd1;
            ok_d      = 1'b1;
            idle_d    = '0;
            acc_stk_d = '0;
            acc_oid_d = '0;
            acc_sid_d = 1'b0;
            acc_prc_d = '0;
            acc_qty_d = '0;
            state_d   = StFields;
          end else begin
            err_d = 1'b1;  // unknown type byte is dropped to resync
          end
        end
      end
      StFields: begin
        if (accept) begin
          idle_d = '0;
          cnt_d  = cnt_q + 4'd1;
          case (cnt_q)
            4'd1: begin
              acc_stk_d = bus.in_data;
              if ({1'b0, bus.in_data} >= StockLim) ok_d = 1'b0;
            end
            4'd2: acc_oid_d[15:8] = bus.in_data;
            4'd3: acc_oid_d[7:0]  = bus.in_data;
            4'd4: begin
              if (type_q == TypeAdd) begin
                if (bus.in_data == 8'h53)      acc_sid_d = 1'b1;
                else if (bus.in_data != 8'h42) ok_d = 1'b0;
              end else begin
                acc_qty_d[15:8] = bus.in_data;
              end
            end
            4'd5: begin
              if (type_q == TypeAdd) acc_prc_d[15:8] = bus.in_data;
              else                   acc_qty_d[7:0]  = bus.in_data;
            end
            4'd6: acc_prc_d[7:0]  = bus.in_data;
            4'd7: acc_qty_d[15:8] = bus.in_data;
            4'd8: acc_qty_d[7:0]  = bus.in_data;
            default: ;
          endcase
          if (cnt_q == last_idx) begin
            if (ok_d) begin
              state_d = StIssue;
              // book_ready seen now yields start in the first StIssue cycle.
              start_d = bus.book_ready;
              req_d   = (type_q == TypeAdd) ? 3'd1 : (type_q == TypeCxl) ? 3'd2 : 3'd3;
              stk_d   = acc_stk_d[STOCK_W-1:0];
              oid_d   = acc_oid_d[ORDER_W-1:0];
              sid_d   = acc_sid_d;
              prc_d   = acc_prc_d[PRICE_W-1:0];
              qty_d   = acc_qty_d[QTY_W-1:0];
              del_d   = (type_q == TypeCxl);
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end
        end else if (idle_q == IdleLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
      StIssue: begin
        if (start_q)             state_d = StIdle;
        else if (bus.book_ready) start_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    msg_cnt_d = (start_q && msg_cnt_q != 16'hFFFF) ? msg_cnt_q + 16'd1 : msg_cnt_q;
    err_cnt_d = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      type_q    <= '0;
      cnt_q     <= '0;
      ok_q      <= 1'b0;
      idle_q    <= '0;
      acc_stk_q <= '0;
      acc_oid_q <= '0;
      acc_sid_q <= 1'b0;
      acc_prc_q <= '0;
      acc_qty_q <= '0;
      req_q     <= '0;
      stk_q     <= '0;
      oid_q     <= '0;
      sid_q     <= 1'b0;
      prc_q     <= '0;
      qty_q     <= '0;
      del_q     <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      ok_q      <= ok_d;
      idle_q    <= idle_d;
      acc_stk_q <= acc_stk_d;
      acc_oid_q <= acc_oid_d;
      acc_sid_q <= acc_sid_d;
      acc_prc_q <= acc_prc_d;
      acc_qty_q <= acc_qty_d;
      req_q     <= req_d;
      stk_q     <= stk_d;
      oid_q     <= oid_d;
      sid_q     <= sid_d;
      prc_q     <= prc_d;
      qty_q     <= qty_d;
      del_q     <= del_d;
      start_q   <= start_d;
      err_q     <= err_d;
      msg_cnt_q <= msg_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.start        = start_q;
  assign bus.request      = req_q;
  assign bus.stock_to_add = stk_q;
  assign bus.order_id     = oid_q;
  assign bus.side         = sid_q;
  assign bus.price        = prc_q;
  assign bus.quantity     = qty_q;
  assign bus.delete       = del_q;
  assign bus.msg_count    = msg_cnt_q;
  assign bus.err_count    = err_cnt_q;
  assign bus.msg_error    = err_q;

endmodule

// File: tb/tb_feed_msg_decoder.sv
// Directed bench for feed_msg_decoder: Add/Cancel/Execute decode, back-pressure, error
// resync, inter-byte timeout and asynchronous reset mid-message / mid-issue.
module tb_feed_msg_decoder;
  localparam int unsigned STOCK_W = 2;
  localparam int unsigned ORDER_W = 16;
  localparam int unsigned PRICE_W = 16;
  localparam int unsigned QTY_W   = 16;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  feed_msg_decoder_if #(
    .STOCK_W(STOCK_W), .ORDER_W(ORDER_W), .PRICE_W(PRICE_W), .QTY_W(QTY_W)
  ) bus ();

  feed_msg_decoder #(
    .STOCK_W(STOCK_W), .ORDER_W(ORDER_W), .PRICE_W(PRICE_W), .QTY_W(QTY_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_100mhz(clk),
    .reset     (rst),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Command monitor: snapshot operands on every start strobe.
  int starts     = 0;
  int start_cyc  = 0;
  int err_pulses = 0;
  logic [31:0] cap_req [16];
  logic [31:0] cap_stk [16];
  logic [31:0] cap_oid [16];
  logic [31:0] cap_sid [16];
  logic [31:0] cap_prc [16];
  logic [31:0] cap_qty [16];
  logic [31:0] cap_del [16];

  always @(negedge clk) begin
    if (bus.start) begin
      cap_req[starts % 16] <= 32'(bus.request);
      cap_stk[starts % 16] <= 32'(bus.stock_to_add);
      cap_oid[starts % 16] <= 32'(bus.order_id);
      cap_sid[starts % 16] <= 32'(bus.side);
      cap_prc[starts % 16] <= 32'(bus.price);
      cap_qty[starts % 16] <= 32'(bus.quantity);
      cap_del[starts % 16] <= 32'(bus.delete);
      start_cyc <= cyc;
      starts    <= starts + 1;
    end
    if (bus.msg_error) err_pulses <= err_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int last_acc  = 0;
  int first_acc = 0;

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        last_acc = cyc;
        done     = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check_eq("send_byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_msg(input logic [7:0] m [9], input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(m[i]);
      if (i == 0) first_acc = last_acc;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m [9];
    int s0, e0, r, bad;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.book_ready = 1'b1;
    tick(2);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_start", 32'(bus.start), 32'd0);
    check_eq("rst_request", 32'(bus.request), 32'd0);
    check_eq("rst_msg_count", 32'(bus.msg_count), 32'd0);
    check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1. Add
    m  = '{8'h41, 8'h01, 8'h12, 8'h34, 8'h42, 8'h00, 8'h64, 8'h00, 8'h0A};
    s0 = starts;
    send_msg(m, 9);
    tick(2);
    check_eq("add_starts", 32'(starts - s0), 32'd1);
    check_eq("add_latency", 32'(start_cyc), 32'(last_acc + 1));
    check_eq("add_req", cap_req[s0 % 16], 32'd1);
    check_eq("add_stock", cap_stk[s0 % 16], 32'd1);
    check_eq("add_oid", cap_oid[s0 % 16], 32'h1234);
    check_eq("add_side", cap_sid[s0 % 16], 32'd0);
    check_eq("add_price", cap_prc[s0 % 16], 32'd100);
    check_eq("add_qty", cap_qty[s0 % 16], 32'd10);
    check_eq("add_del", cap_del[s0 % 16], 32'd0);
    check_eq("add_msg_count", 32'(bus.msg_count), 32'd1);
    check_eq("add_hold_price", 32'(bus.price), 32'd100);

    // 2. Cancel then Execute back-to-back
    m  = '{8'h58, 8'h02, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    s0 = starts;
    send_msg(m, 4);
    r  = last_acc;
    m  = '{8'h45, 8'h03, 8'h00, 8'h07, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_msg(m, 6);
    check_eq("b2b_next_byte", 32'(first_acc), 32'(r + 2));
    tick(2);
    check_eq("b2b_starts", 32'(starts - s0), 32'd2);
    check_eq("cxl_req", cap_req[s0 % 16], 32'd2);
    check_eq("cxl_del", cap_del[s0 % 16], 32'd1);
    check_eq("cxl_oid", cap_oid[s0 % 16], 32'h1234);
    check_eq("cxl_stock", cap_stk[s0 % 16], 32'd2);
    check_eq("cxl_qty", cap_qty[s0 % 16], 32'd0);
    check_eq("exe_req", cap_req[(s0 + 1) % 16], 32'd3);
    check_eq("exe_oid", cap_oid[(s0 + 1) % 16], 32'd7);
    check_eq("exe_qty", cap_qty[(s0 + 1) % 16], 32'd5);
    check_eq("exe_stock", cap_stk[(s0 + 1) % 16], 32'd3);
    check_eq("exe_del", cap_del[(s0 + 1) % 16], 32'd0);
    check_eq("exe_price", cap_prc[(s0 + 1) % 16], 32'd0);
    check_eq("b2b_msg_count", 32'(bus.msg_count), 32'd3);

    // 3. Back-pressure: stock 0, oid 5, sell, price 0x100, qty 3
    bus.book_ready = 1'b0;
    m  = '{8'h41, 8'h00, 8'h00, 8'h05, 8'h53, 8'h01, 8'h00, 8'h00, 8'h03};
    s0 = starts;
    send_msg(m, 9);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready || bus.start || bus.request != 3'd1 || bus.price != 16'h0100 ||
          bus.side != 1'b1 || bus.quantity != 16'd3 || bus.order_id != 16'd5)
        bad++;
    end
    check_eq("bp_hold_violations", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    bus.book_ready = 1'b1;
    r = cyc;
    tick(3);
    check_eq("bp_starts", 32'(starts - s0), 32'd1);
    check_eq("bp_start_cycle", 32'(start_cyc), 32'(r + 1));
    check_eq("bp_side", cap_sid[s0 % 16], 32'd1);
    check_eq("bp_price", cap_prc[s0 % 16], 32'h100);

    // 4. Errors
    e0 = err_pulses;
    send_byte(8'h5A);
    tick(1);
    check_eq("unk_err_count", 32'(bus.err_count), 32'd1);
    check_eq("unk_pulse", 32'(err_pulses - e0), 32'd1);
    check_eq("unk_idle_ready", 32'(bus.in_ready), 32'd1);
    m  = '{8'h41, 8'h07, 8'h12, 8'h34, 8'h42, 8'h00, 8'h01, 8'h00, 8'h01};
    s0 = starts;
    send_msg(m, 9);
    tick(3);
    check_eq("bad_stock_err", 32'(bus.err_count), 32'd2);
    check_eq("bad_stock_nostart", 32'(starts - s0), 32'd0);
    m  = '{8'h41, 8'h01, 8'h00, 8'h01, 8'h51, 8'h00, 8'h01, 8'h00, 8'h01};
    send_msg(m, 9);
    tick(3);
    check_eq("bad_side_err", 32'(bus.err_count), 32'd3);
    check_eq("bad_side_nostart", 32'(starts - s0), 32'd0);
    check_eq("err_pulses", 32'(err_pulses - e0), 32'd3);

    // 5. Timeout after 'A' + stock, from a clean reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    m = '{8'h41, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_msg(m, 2);
    tick(7);
    check_eq("timeout_not_early", 32'(bus.err_count), 32'd0);
    tick(1);
    check_eq("timeout_err_count", 32'(bus.err_count), 32'd1);
    check_eq("timeout_pulse", 32'(bus.msg_error), 32'd1);
    m  = '{8'h41, 8'h03, 8'hAB, 8'hCD, 8'h53, 8'hFF, 8'hFF, 8'h12, 8'h34};
    s0 = starts;
    send_msg(m, 9);
    tick(2);
    check_eq("post_to_starts", 32'(starts - s0), 32'd1);
    check_eq("post_to_stock", cap_stk[s0 % 16], 32'd3);
    check_eq("post_to_oid", cap_oid[s0 % 16], 32'hABCD);
    check_eq("post_to_side", cap_sid[s0 % 16], 32'd1);
    check_eq("post_to_price", cap_prc[s0 % 16], 32'hFFFF);
    check_eq("post_to_qty", cap_qty[s0 % 16], 32'h1234);
    check_eq("post_to_msg_count", 32'(bus.msg_count), 32'd1);

    // 6. Asynchronous reset mid-message and while issuing
    m  = '{8'h41, 8'h01, 8'h12, 8'h34, 8'h42, 8'h00, 8'h64, 8'h00, 8'h0A};
    s0 = starts;
    send_msg(m, 5);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_msg_count", 32'(bus.msg_count), 32'd0);
    check_eq("rst_mid_err_count", 32'(bus.err_count), 32'd0);
    check_eq("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_mid_oid", 32'(bus.order_id), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check_eq("rst_mid_ready_after", 32'(bus.in_ready), 32'd1);
    bus.book_ready = 1'b0;
    send_msg(m, 9);
    tick(2);
    check_eq("issue_wait_req", 32'(bus.request), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_issue_req", 32'(bus.request), 32'd0);
    check_eq("rst_issue_price", 32'(bus.price), 32'd0);
    check_eq("rst_issue_in_ready", 32'(bus.in_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    bus.book_ready = 1'b1;
    tick(5);
    check_eq("rst_no_start", 32'(starts - s0), 32'd0);
    check_eq("rst_issue_idle", 32'(bus.in_ready), 32'd1);
    send_msg(m, 9);
    tick(2);
    check_eq("clean_starts", 32'(starts - s0), 32'd1);
    check_eq("clean_req", cap_req[s0 % 16], 32'd1);
    check_eq("clean_oid", cap_oid[s0 % 16], 32'h1234);
    check_eq("clean_msg_count", 32'(bus.msg_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
